// File: rtl/fft_peak_pkg.sv
// Shared types and width helpers for the FFT band peak picker.
package fft_peak_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SWEEP    = 3'd1,
        DRAIN    = 3'd2,
        EMIT     = 3'd3,
        FIN      = 3'd4,
        WAIT_CLR = 3'd5
    } state_t;

    localparam int BFP_EXP_W = 8;

    function automatic int mag_w(input int dw);
        return dw + 1;
    endfunction

    // A single band still needs a one-bit index signal.
    function automatic int band_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/fft_mag_abs_sum.sv
// Combinational |re| + |im| magnitude; the most negative input maps to 2^(DW-1) exactly.
module fft_mag_abs_sum
    import fft_peak_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] i_re,
    input  logic signed [DW-1:0] i_im,
    output logic [DW:0]          o_mag
);

    localparam int MW = mag_w(DW);

    logic [MW-1:0] w_re_ext;
    logic [MW-1:0] w_im_ext;
    logic [MW-1:0] w_re_abs;
    logic [MW-1:0] w_im_abs;

    // One guard bit keeps the negation of the most negative value exact.
    assign w_re_ext = {i_re[DW-1], i_re};
    assign w_im_ext = {i_im[DW-1], i_im};
    assign w_re_abs = i_re[DW-1] ? (~w_re_ext + MW'(1)) : w_re_ext;
    assign w_im_abs = i_im[DW-1] ? (~w_im_ext + MW'(1)) : w_im_ext;
    assign o_mag    = w_re_abs + w_im_abs;

endmodule

// File: rtl/fft_band_peak_picker.sv
// Sweeps the positive half of an FFT result, keeps the strongest bin per octave band and
// streams one peak record per band. Optional macro FFT_PEAK_THRESHOLD_EN adds pk_thresh.
module fft_band_peak_picker
    import fft_peak_pkg::*;
#(
    parameter int FFT_LENGTH     = 1024,
    parameter int FFT_DW         = 16,
    parameter int BAND_BASE_LOG2 = 3,
    parameter int FFT_N          = $clog2(FFT_LENGTH),
    parameter int NUM_BANDS      = FFT_N - 1 - BAND_BASE_LOG2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fft_done,
    input  logic [BFP_EXP_W-1:0]          fft_bfpexp,
    output logic                          fin,
    output logic                          dmaact,
    output logic [FFT_N-1:0]              dmaa,
    input  logic signed [FFT_DW-1:0]      dmadr_real,
    input  logic signed [FFT_DW-1:0]      dmadr_imag,
    output logic                          pk_valid,
    input  logic                          pk_ready,
    output logic [band_w(NUM_BANDS)-1:0]  pk_band,
    output logic [FFT_N-2:0]              pk_bin,
    output logic [FFT_DW:0]               pk_mag,
    output logic [BFP_EXP_W-1:0]          pk_exp,
    output logic                          pk_last
`ifdef FFT_PEAK_THRESHOLD_EN
    ,
    input  logic [FFT_DW:0]               pk_thresh
`endif
);

    localparam int MW   = mag_w(FFT_DW);
    localparam int BW   = band_w(NUM_BANDS);
    localparam int BINW = FFT_N - 1;
    localparam logic [FFT_N-1:0] FIRST_BIN = FFT_N'(1) << BAND_BASE_LOG2;
    localparam logic [FFT_N-1:0] LAST_BIN  = FFT_N'(FFT_LENGTH / 2 - 1);

    state_t                 r_state;
    logic                   r_fin;
    logic                   r_dmaact;
    logic [FFT_N-1:0]       r_dmaa;
    logic [BW-1:0]          r_cur_band;
    logic                   r_rd_valid;
    logic [BINW-1:0]        r_rd_bin;
    logic [BW-1:0]          r_rd_band;
    logic [BFP_EXP_W-1:0]   r_exp;
    logic [NUM_BANDS-1:0]   r_pass;
    logic                   r_pk_valid;
    logic                   r_pk_last;
    logic [BW-1:0]          r_pk_band;
    logic [BINW-1:0]        r_pk_bin;
    logic [MW-1:0]          r_pk_mag;

    logic [MW-1:0]          r_best_mag [NUM_BANDS];
    logic [BINW-1:0]        r_best_bin [NUM_BANDS];
    logic [MW-1:0]          w_best_mag_nxt [NUM_BANDS];
    logic [BINW-1:0]        w_best_bin_nxt [NUM_BANDS];

    logic [MW-1:0]          w_mag;
    logic                   w_band_wrap;
    logic [NUM_BANDS-1:0]   w_pass_now;
    logic [NUM_BANDS-1:0]   w_pass_use;
    logic [BW:0]            w_start;
    logic                   w_found;
    logic                   w_more;
    logic [BW-1:0]          w_sel;

    fft_mag_abs_sum #(
        .DW    (FFT_DW)
    ) u_mag (
        .i_re  (dmadr_real),
        .i_im  (dmadr_imag),
        .o_mag (w_mag)
    );

    // Address ending in all ones means the next address starts a new octave.
    assign w_band_wrap = ((r_dmaa & (r_dmaa + FFT_N'(1))) == '0);

    // Candidate band bests including the word returning this cycle; strict > keeps the lowest bin on ties.
    always_comb begin
        for (int k = 0; k < NUM_BANDS; k++) begin
            w_best_mag_nxt[k] = (r_rd_valid && (r_rd_band == BW'(k)) && (w_mag > r_best_mag[k]))
                                ? w_mag : r_best_mag[k];
            w_best_bin_nxt[k] = (r_rd_valid && (r_rd_band == BW'(k)) && (w_mag > r_best_mag[k]))
                                ? r_rd_bin : r_best_bin[k];
        end
    end

`ifdef FFT_PEAK_THRESHOLD_EN
    // Per-band pass flags against the threshold, latched during DRAIN.
    always_comb begin
        w_pass_now = '0;
        for (int k = 0; k < NUM_BANDS; k++) begin
            w_pass_now[k] = (w_best_mag_nxt[k] >= pk_thresh);
        end
    end
`else
    assign w_pass_now = '1;
`endif

    assign w_pass_use = (r_state == DRAIN) ? w_pass_now : r_pass;
    assign w_start    = (r_state == DRAIN) ? '0 : ({1'b0, r_pk_band} + (BW + 1)'(1));

    // Lowest passing band at or after w_start, and whether another passing band follows it.
    always_comb begin
        w_found = 1'b0;
        w_more  = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_BANDS; k++) begin
            w_more  = w_more | (w_found & w_pass_use[k] & (k >= int'(w_start)));
            w_sel   = (!w_found && w_pass_use[k] && (k >= int'(w_start))) ? BW'(k) : w_sel;
            w_found = w_found | (w_pass_use[k] & (k >= int'(w_start)));
        end
    end

    // Band-best registers: cleared to (0, first bin) as a sweep starts, otherwise take the candidate.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_BANDS; k++) begin
            if (!reset || (r_state == IDLE && fft_done)) begin
                r_best_mag[k] <= '0;
                r_best_bin[k] <= BINW'(1) << (BAND_BASE_LOG2 + k);
            end else begin
                r_best_mag[k] <= w_best_mag_nxt[k];
                r_best_bin[k] <= w_best_bin_nxt[k];
            end
        end
    end

    // Frame sequencer, DMA address generation and the registered peak stream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fin      <= 1'b0;
            r_dmaact   <= 1'b0;
            r_dmaa     <= '0;
            r_cur_band <= '0;
            r_rd_valid <= 1'b0;
            r_rd_bin   <= '0;
            r_rd_band  <= '0;
            r_exp      <= '0;
            r_pass     <= '0;
            r_pk_valid <= 1'b0;
            r_pk_last  <= 1'b0;
            r_pk_band  <= '0;
            r_pk_bin   <= '0;
            r_pk_mag   <= '0;
        end else begin
            r_rd_valid <= r_dmaact;
            r_rd_bin   <= r_dmaa[BINW-1:0];
            r_rd_band  <= r_cur_band;
            r_fin      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fft_done) begin
                        r_state    <= SWEEP;
                        r_exp      <= fft_bfpexp;
                        r_dmaact   <= 1'b1;
                        r_dmaa     <= FIRST_BIN;
                        r_cur_band <= '0;
                    end
                end
                SWEEP: begin
                    if (r_dmaa == LAST_BIN) begin
                        r_state  <= DRAIN;
                        r_dmaact <= 1'b0;
                        r_dmaa   <= '0;
                    end else begin
                        r_dmaa <= r_dmaa + FFT_N'(1);
                        if (w_band_wrap) begin
                            r_cur_band <= r_cur_band + BW'(1);
                        end
                    end
                end
                DRAIN: begin
                    r_state    <= EMIT;
                    r_pass     <= w_pass_now;
                    r_pk_valid <= w_found;
                    if (w_found) begin
                        r_pk_band <= w_sel;
                        r_pk_bin  <= w_best_bin_nxt[w_sel];
                        r_pk_mag  <= w_best_mag_nxt[w_sel];
                        r_pk_last <= !w_more;
                    end
                end
                EMIT: begin
                    if (!r_pk_valid) begin
                        r_state <= FIN;
                        r_fin   <= 1'b1;
                    end else if (pk_ready) begin
                        if (r_pk_last) begin
                            r_state    <= FIN;
                            r_fin      <= 1'b1;
                            r_pk_valid <= 1'b0;
                            r_pk_last  <= 1'b0;
                        end else begin
                            r_pk_valid <= w_found;
                            if (w_found) begin
                                r_pk_band <= w_sel;
                                r_pk_bin  <= w_best_bin_nxt[w_sel];
                                r_pk_mag  <= w_best_mag_nxt[w_sel];
                                r_pk_last <= !w_more;
                            end
                        end
                    end
                end
                FIN: begin
                    r_state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!fft_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fin      = r_fin;
    assign dmaact   = r_dmaact;
    assign dmaa     = r_dmaa;
    assign pk_valid = r_pk_valid;
    assign pk_band  = r_pk_band;
    assign pk_bin   = r_pk_bin;
    assign pk_mag   = r_pk_mag;
    assign pk_exp   = r_exp;
    assign pk_last  = r_pk_last;

endmodule

// File: tb/tb_fft_band_peak_picker.sv
// Directed bench for fft_band_peak_picker (FFT_LENGTH=64, BAND_BASE_LOG2=2: bands 4-7, 8-15, 16-31).
module tb_fft_band_peak_picker;

    logic               clk = 1'b0;
    logic               reset;
    logic               fft_done;
    logic [7:0]         fft_bfpexp;
    logic               fin;
    logic               dmaact;
    logic [5:0]         dmaa;
    logic signed [15:0] dmadr_real;
    logic signed [15:0] dmadr_imag;
    logic               pk_valid;
    logic               pk_ready;
    logic [1:0]         pk_band;
    logic [4:0]         pk_bin;
    logic [16:0]        pk_mag;
    logic [7:0]         pk_exp;
    logic               pk_last;
`ifdef FFT_PEAK_THRESHOLD_EN
    logic [16:0]        pk_thresh;
`endif

    logic signed [15:0] mem_re [64];
    logic signed [15:0] mem_im [64];

    int n_pass  = 0;
    int n_total = 0;

    int rec_band [4];
    int rec_bin  [4];
    int rec_mag  [4];
    int rec_last [4];
    int rec_exp  [4];
    int nrec, fin_cyc, last_hs, fin_extra, first_valid;
    bit held_ok;

    typedef struct {
        string      name;
        int         bin_a, re_a, im_a;
        int         bin_b, re_b, im_b;
        logic [7:0] exp_in;
        int         eb0, eb1, eb2;
        int         em0, em1, em2;
    } vec_t;

    vec_t vecs [5];

    fft_band_peak_picker #(
        .FFT_LENGTH     (64),
        .FFT_DW         (16),
        .BAND_BASE_LOG2 (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fft_done   (fft_done),
        .fft_bfpexp (fft_bfpexp),
        .fin        (fin),
        .dmaact     (dmaact),
        .dmaa       (dmaa),
        .dmadr_real (dmadr_real),
        .dmadr_imag (dmadr_imag),
        .pk_valid   (pk_valid),
        .pk_ready   (pk_ready),
        .pk_band    (pk_band),
        .pk_bin     (pk_bin),
        .pk_mag     (pk_mag),
        .pk_exp     (pk_exp),
        .pk_last    (pk_last)
`ifdef FFT_PEAK_THRESHOLD_EN
        ,
        .pk_thresh  (pk_thresh)
`endif
    );

    always #5 clk = ~clk;

    // Result RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (dmaact) begin
            dmadr_real <= mem_re[dmaa];
            dmadr_imag <= mem_im[dmaa];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic load_mem(input int ba, input int ra, input int ia,
                            input int bb, input int rb, input int ib);
        for (int i = 0; i < 64; i++) begin
            mem_re[i] = 16'sd0;
            mem_im[i] = 16'sd0;
        end
        mem_re[ba] = 16'(ra);
        mem_im[ba] = 16'(ia);
        mem_re[bb] = 16'(rb);
        mem_im[bb] = 16'(ib);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one frame; cycle 0 is the cycle in which fft_done is first sampled high.
    task automatic run_frame(input int stall, input logic [7:0] exp_in);
        int k;
        int stalls_left;
        logic [63:0] snap;
        bit snap_v;
        nrec = 0; fin_cyc = -1; last_hs = -1; fin_extra = 0; first_valid = -1;
        held_ok = 1'b1; stalls_left = stall; snap_v = 1'b0; snap = '0;
        fft_bfpexp = exp_in;
        fft_done   = 1'b1;
        k = 0;
        while (fin_cyc < 0 && k < 300) begin
            step();
            k++;
            if (k == 1) begin
                fft_bfpexp = 8'h00;
                chk("dmaact_first", 32'(dmaact), 32'd1);
                chk("dmaa_first", 32'(dmaa), 32'd4);
            end
            if (k == 29) chk("dmaact_drain", 32'(dmaact), 32'd0);
            if (pk_valid && first_valid < 0) first_valid = k;
            pk_ready = 1'b1;
            if (pk_valid && stalls_left > 0) begin
                pk_ready = 1'b0;
                stalls_left--;
            end
            if (pk_valid && (stall > 0) && (nrec == 0)) begin
                if (!snap_v) begin
                    snap   = {31'd0, pk_band, pk_bin, pk_mag, pk_exp, pk_last};
                    snap_v = 1'b1;
                end else if (snap != {31'd0, pk_band, pk_bin, pk_mag, pk_exp, pk_last}) begin
                    held_ok = 1'b0;
                end
            end
            if (pk_valid && pk_ready) begin
                if (nrec < 4) begin
                    rec_band[nrec] = int'(pk_band);
                    rec_bin[nrec]  = int'(pk_bin);
                    rec_mag[nrec]  = int'(pk_mag);
                    rec_last[nrec] = int'(pk_last);
                    rec_exp[nrec]  = int'(pk_exp);
                end
                nrec++;
                last_hs = k;
            end
            if (fin) fin_cyc = k;
        end
        if (fin_cyc < 0) chk("fin_timeout", 32'd0, 32'd1);
        step();
        fft_done = 1'b0;
        pk_ready = 1'b0;
        if (fin) fin_extra++;
        repeat (3) begin
            step();
            if (fin || pk_valid) fin_extra++;
        end
    endtask

    int bad;

    initial begin
        reset = 1'b0; fft_done = 1'b0; fft_bfpexp = 8'h00; pk_ready = 1'b0;
`ifdef FFT_PEAK_THRESHOLD_EN
        pk_thresh = 17'd0;
`endif
        load_mem(0, 0, 0, 0, 0, 0);
        repeat (3) step();

        chk("rst_dmaact", 32'(dmaact), 32'd0);
        chk("rst_dmaa", 32'(dmaa), 32'd0);
        chk("rst_fin", 32'(fin), 32'd0);
        chk("rst_pk_valid", 32'(pk_valid), 32'd0);
        chk("rst_pk_last", 32'(pk_last), 32'd0);
        chk("rst_pk_band", 32'(pk_band), 32'd0);
        chk("rst_pk_bin", 32'(pk_bin), 32'd0);
        chk("rst_pk_mag", 32'(pk_mag), 32'd0);
        chk("rst_pk_exp", 32'(pk_exp), 32'd0);
        reset = 1'b1;
        step();

        vecs[0] = '{"tone",    10, 1000, -500,   0,     0,      0, 8'hFD, 4, 10, 16,     0, 1500,     0};
        vecs[1] = '{"tie",     16,  100, -200,  20,  -300,      0, 8'h05, 4,  8, 16,     0,    0,   300};
        vecs[2] = '{"mostneg",  5, -32768, -32768, 31, 32767, -32768, 8'h80, 5, 8, 31, 65536, 0, 65535};
        vecs[3] = '{"replace",  8,   10,   10,  15,     0,    -21, 8'h7F, 4, 15, 16,     0,   21,     0};
        vecs[4] = '{"band0tie", 4,   -1,    0,   6,     0,      1, 8'h11, 4,  8, 16,     1,    0,     0};

        for (int v = 0; v < 5; v++) begin
            load_mem(vecs[v].bin_a, vecs[v].re_a, vecs[v].im_a,
                     vecs[v].bin_b, vecs[v].re_b, vecs[v].im_b);
            run_frame(0, vecs[v].exp_in);
            chk({vecs[v].name, "_nrec"}, 32'(nrec), 32'd3);
            chk({vecs[v].name, "_first_valid"}, 32'(first_valid), 32'd30);
            chk({vecs[v].name, "_fin_cycle"}, 32'(fin_cyc), 32'd33);
            chk({vecs[v].name, "_fin_once"}, 32'(fin_extra), 32'd0);
            for (int r = 0; r < 3; r++) begin
                chk({vecs[v].name, "_band"}, 32'(rec_band[r]), 32'(r));
                chk({vecs[v].name, "_last"}, 32'(rec_last[r]), (r == 2) ? 32'd1 : 32'd0);
                chk({vecs[v].name, "_exp"}, 32'(rec_exp[r]), 32'(vecs[v].exp_in));
            end
            chk({vecs[v].name, "_bin0"}, 32'(rec_bin[0]), 32'(vecs[v].eb0));
            chk({vecs[v].name, "_bin1"}, 32'(rec_bin[1]), 32'(vecs[v].eb1));
            chk({vecs[v].name, "_bin2"}, 32'(rec_bin[2]), 32'(vecs[v].eb2));
            chk({vecs[v].name, "_mag0"}, 32'(rec_mag[0]), 32'(vecs[v].em0));
            chk({vecs[v].name, "_mag1"}, 32'(rec_mag[1]), 32'(vecs[v].em1));
            chk({vecs[v].name, "_mag2"}, 32'(rec_mag[2]), 32'(vecs[v].em2));
        end

        // Backpressure: first record held for five cycles, handshakes at 35, 36, 37.
        load_mem(10, 1000, -500, 0, 0, 0);
        run_frame(5, 8'h21);
        chk("bp_nrec", 32'(nrec), 32'd3);
        chk("bp_hold_stable", 32'(held_ok), 32'd1);
        chk("bp_last_hs", 32'(last_hs), 32'd37);
        chk("bp_fin_cycle", 32'(fin_cyc), 32'd38);
        chk("bp_bin1", 32'(rec_bin[1]), 32'd10);
        chk("bp_mag1", 32'(rec_mag[1]), 32'd1500);

        // Reset in the middle of the sweep.
        load_mem(10, 1000, -500, 0, 0, 0);
        fft_bfpexp = 8'h33;
        fft_done   = 1'b1;
        repeat (7) step();
        chk("rst_mid_dmaact_before", 32'(dmaact), 32'd1);
        reset    = 1'b0;
        fft_done = 1'b0;
        step();
        chk("rst_mid_dmaact", 32'(dmaact), 32'd0);
        chk("rst_mid_dmaa", 32'(dmaa), 32'd0);
        chk("rst_mid_pk_exp", 32'(pk_exp), 32'd0);
        reset = 1'b1;
        bad = 0;
        repeat (40) begin
            step();
            if (fin || pk_valid || dmaact) bad++;
        end
        chk("rst_mid_quiet", 32'(bad), 32'd0);
        run_frame(0, 8'h44);
        chk("rerun_nrec", 32'(nrec), 32'd3);
        chk("rerun_bin1", 32'(rec_bin[1]), 32'd10);
        chk("rerun_mag1", 32'(rec_mag[1]), 32'd1500);
        chk("rerun_exp", 32'(rec_exp[0]), 32'h44);
        chk("rerun_fin_cycle", 32'(fin_cyc), 32'd33);

`ifdef FFT_PEAK_THRESHOLD_EN
        pk_thresh = 17'd1000;
        load_mem(10, 1000, -500, 0, 0, 0);
        run_frame(0, 8'h01);
        chk("thr_nrec", 32'(nrec), 32'd1);
        chk("thr_band", 32'(rec_band[0]), 32'd1);
        chk("thr_bin", 32'(rec_bin[0]), 32'd10);
        chk("thr_mag", 32'(rec_mag[0]), 32'd1500);
        chk("thr_last", 32'(rec_last[0]), 32'd1);
        chk("thr_fin_cycle", 32'(fin_cyc), 32'd31);
        pk_thresh = 17'd2000;
        run_frame(0, 8'h02);
        chk("thr_none_nrec", 32'(nrec), 32'd0);
        chk("thr_none_fin_cycle", 32'(fin_cyc), 32'd31);
        pk_thresh = 17'd0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_band_peak_picker.md
# fft_band_peak_picker

- Downstream consumer of the radix-2 FFT core.
- Sequence per frame:
  - When the FFT reports `done`, sweep the positive-frequency half of the result through the DMA read bus.
  - Compute an |re|+|im| magnitude per bin.
  - Track the strongest bin inside each octave band.
  - Emit one peak record per band on a valid/ready stream.
  - Pulse `fin` to release the FFT core back to input streaming.
- Peak records feed the fingerprint hasher.

## Interface
Parameters:
- FFT_LENGTH, 1024, FFT frame length, 2^N; must match the FFT core.
- FFT_DW, 16, FFT data width; must match the FFT core.
- BAND_BASE_LOG2, 3, first analysed bin is 2^BAND_BASE_LOG2; must be < FFT_N-1.
- FFT_N, $clog2(FFT_LENGTH), derived; do not override.
- NUM_BANDS, FFT_N-1-BAND_BASE_LOG2, derived; do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk.
- fft_done  in  1  FFT core `done`.
- fft_bfpexp  in  8  signed block-floating-point exponent from the FFT core.
- fin  out  1  one-cycle pulse that releases the FFT core.
- dmaact  out  1  DMA read enable.
- dmaa  out  FFT_N  DMA bin address.
- dmadr_real  in  FFT_DW  signed real part, valid one cycle after the address.
- dmadr_imag  in  FFT_DW  signed imaginary part, valid one cycle after the address.
- pk_valid  out  1  peak record valid.
- pk_ready  in  1  consumer accepts the record.
- pk_band  out  $clog2(NUM_BANDS)  band index.
- pk_bin  out  FFT_N-1  bin of the peak.
- pk_mag  out  FFT_DW+1  unsigned magnitude of the peak.
- pk_exp  out  8  exponent captured at sweep start.
- pk_last  out  1  marks the final record of the frame.

## Operation
- Bands: band k covers bins [2^(BAND_BASE_LOG2+k), 2^(BAND_BASE_LOG2+k+1)). Total sweep S = FFT_LENGTH/2 - 2^BAND_BASE_LOG2 bins.
- Magnitude: mag = |re| + |im|, width FFT_DW+1, unsigned. |−2^(FFT_DW−1)| = 2^(FFT_DW−1) exactly, with no saturation.
- Peak selection: a band's best is replaced only when mag is strictly greater. Ties keep the lowest bin. All-zero band reports mag 0 at the band's first bin.
- FSM states and transitions:
  - IDLE → SWEEP when fft_done=1. On entry to SWEEP: capture fft_bfpexp, clear all band bests to (mag 0, first bin).
  - SWEEP: dmaact=1, dmaa=address counter from 2^BAND_BASE_LOG2 to FFT_LENGTH/2-1, incrementing every cycle with no stalls. The address and band index are delayed one cycle to align with returned data.
  - DRAIN: one cycle to absorb the last returned word.
  - EMIT: records are output in ascending band order. A record advances on pk_valid&&pk_ready.
  - FIN: fin=1 for exactly one cycle.
  - WAIT_CLR: hold until fft_done=0, then go to IDLE. This prevents a re-trigger on the stale done.
- Stream rule: while pk_valid=1 and pk_ready=0, all pk_* outputs hold stable.
- Reset (any state, including mid-sweep or mid-EMIT): next state IDLE; partial results discarded; no fin issued.
- Reset values: dmaact=0, dmaa=0, fin=0, pk_valid=0, pk_last=0, pk_band=0, pk_bin=0, pk_mag=0, pk_exp=0.

## Timing
- Cycle 0: fft_done first sampled 1 in IDLE.
- Cycles 1..S: dmaact=1.
- Cycle S+1: DRAIN.
- Cycle S+2: first pk_valid.
- Best case: NUM_BANDS records on consecutive cycles with pk_ready=1. fin pulses the cycle after the last handshake.
- fin is never asserted before the last handshake completes.
- Frame cycle count with no backpressure: S + 2 + NUM_BANDS + 1, plus WAIT_CLR.
- Data from dmaa issued at cycle t is consumed at t+1 only. Band-best registers update at the end of t+1.

## Configuration
- FFT_PEAK_THRESHOLD_EN
  - Defined:
    - Adds input port `pk_thresh` (FFT_DW+1 bits).
    - Bands whose best mag < pk_thresh are not emitted.
    - pk_last sits on the last passing band. Pass flags are computed in DRAIN.
    - If no band passes, no records are emitted and fin follows EMIT after one cycle.
  - Undefined: the port is absent and every band is emitted.

## Structure
- Package fft_peak_pkg:
  - state enum (IDLE, SWEEP, DRAIN, EMIT, FIN, WAIT_CLR).
  - Width localparam helpers for magnitude and band index.
- Sub-module fft_mag_abs_sum: combinational |re|+|im|, width FFT_DW+1.

## Test plan
Common setup:
- Default config is FFT_LENGTH=64, BAND_BASE_LOG2=2, which gives 3 bands: 4-7, 8-15, 16-31.
- The DMA model is a RAM with one-cycle read latency.
- fft_done drops one cycle after fin.

Scenarios:
- Tone test: bin10 = (1000, −500), all other bins 0, pk_ready=1 → records (0,4,0), (1,10,1500), (2,16,0); pk_last on band 2; fin at cycle S+2+3 = 33.
- Tie test: bins 16 and 20 both mag 300 → band 2 reports bin 16.
- Backpressure test: pk_ready=0 for 5 cycles on the first record → record held bit-stable; fin only after the third handshake.
- Most-negative test: bin 5 = (−32768, −32768) → pk_mag=65536, no overflow.
- Reset test: reset=0 at sweep cycle 7 → dmaact=0 next cycle, no fin; a fresh done re-runs the full frame correctly.
- Threshold test: with FFT_PEAK_THRESHOLD_EN defined, pk_thresh=1000, tone data from the first scenario → single record for band 1 with pk_last=1, then fin.
